// File: rtl/ice40_pll_lock_qual.sv
// Lock qualifier and frequency monitor for the PLL output domain.
// Qualifies raw LOCK over time and per-window pll_clk counts of a reference toggle.
module ice40_pll_lock_qual #(
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned LOCK_STABLE  = 4096,
  parameter int unsigned CNT_MIN      = 0,
  parameter int unsigned CNT_MAX      = 65534,
  parameter int unsigned GOOD_WINDOWS = 4,
  parameter int unsigned BAD_WINDOWS  = 2
) (
  input  logic                 pll_clk,
  input  logic                 pll_rst,
  input  logic                 i_lock,
  input  logic                 i_ref_toggle,
  input  logic                 i_fault_clr,
  output logic                 o_ready,
  output logic                 o_fault,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_count_valid
);

  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned GW = $clog2(GOOD_WINDOWS + 1);
  localparam int unsigned BW = $clog2(BAD_WINDOWS + 1);

  localparam logic [CNT_WIDTH-1:0] MIN_L  = CNT_WIDTH'(CNT_MIN);
  localparam logic [CNT_WIDTH-1:0] SPAN_L = CNT_WIDTH'(CNT_MAX - CNT_MIN);
  localparam logic [SW-1:0]        STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [GW-1:0]        GOOD_LAST   = GW'(GOOD_WINDOWS - 1);
  localparam logic [BW-1:0]        BAD_LAST    = BW'(BAD_WINDOWS - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, MEASURE, RUN} state_t;

  state_t               state_q;
  logic                 lock_meta_q, lock_s_q;
  logic                 ref_meta_q, ref_s_q, ref_d_q, ref_edge_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 count_valid_q;
  logic [SW-1:0]        stable_q;
  logic [GW-1:0]        good_q;
  logic [BW-1:0]        bad_q;
  logic                 armed_q;
  logic                 ready_q;
  logic                 fault_q;
  logic                 in_range_c;

  // Window counter reloads to 1 on a reference edge and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (ref_edge_q) begin
      cnt_d = CNT_WIDTH'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Offset compare: wraps below CNT_MIN, so one unsigned test covers both bounds.
  assign in_range_c = (cnt_q - MIN_L) <= SPAN_L;

  always_ff @(posedge pll_clk or posedge pll_rst) begin
    if (pll_rst) begin
      state_q       <= WAIT_LOCK;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      ref_meta_q    <= 1'b0;
      ref_s_q       <= 1'b0;
      ref_d_q       <= 1'b0;
      ref_edge_q    <= 1'b0;
      cnt_q         <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      stable_q      <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      armed_q       <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      lock_meta_q   <= i_lock;
      lock_s_q      <= lock_meta_q;
      ref_meta_q    <= i_ref_toggle;
      ref_s_q       <= ref_meta_q;
      ref_d_q       <= ref_s_q;
      ref_edge_q    <= ref_s_q ^ ref_d_q;
      cnt_q         <= cnt_d;
      count_valid_q <= ref_edge_q && armed_q;
      if (ref_edge_q && armed_q) begin
        count_q <= cnt_q;
      end
      // A later set in the state logic overrides this clear.
      if (i_fault_clr) begin
        fault_q <= 1'b0;
      end

      case (state_q)
        WAIT_LOCK: begin
          stable_q <= '0;
          good_q   <= '0;
          bad_q    <= '0;
          armed_q  <= 1'b0;
          ready_q  <= 1'b0;
          if (lock_s_q) begin
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (!lock_s_q) begin
            state_q <= WAIT_LOCK;
          end else if (stable_q == STABLE_LAST) begin
            state_q <= MEASURE;
          end else begin
            stable_q <= stable_q + SW'(1);
          end
        end
        MEASURE: begin
          if (!lock_s_q) begin
            state_q <= WAIT_LOCK;
            ready_q <= 1'b0;
          end else if (ref_edge_q) begin
            if (!armed_q) begin
              armed_q <= 1'b1;
            end else if (in_range_c) begin
              if (good_q == GOOD_LAST) begin
                state_q <= RUN;
                ready_q <= 1'b1;
                bad_q   <= '0;
              end else begin
                good_q <= good_q + GW'(1);
              end
            end else begin
              good_q <= '0;
            end
          end
        end
        RUN: begin
          if (!lock_s_q) begin
            state_q <= WAIT_LOCK;
            ready_q <= 1'b0;
            fault_q <= 1'b1;
          end else if (ref_edge_q) begin
            if (in_range_c) begin
              bad_q <= '0;
            end else if (bad_q == BAD_LAST) begin
              state_q <= MEASURE;
              ready_q <= 1'b0;
              fault_q <= 1'b1;
              good_q  <= '0;
            end else begin
              bad_q <= bad_q + BW'(1);
            end
          end
        end
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  assign o_ready       = ready_q;
  assign o_fault       = fault_q;
  assign o_count       = count_q;
  assign o_count_valid = count_valid_q;

endmodule
